// File: rtl/crc16_pkg.sv
// Shared types and constants for the CRC16 (X^16+X^12+X^5+1) transmit framer.
// Holds the framer state encoding and the byte-wide CRC step used by the datapath.
package crc16_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'h0000;

   typedef enum logic [1:0] {
      DATA   = 2'd0,
      CRC_HI = 2'd1,
      CRC_LO = 2'd2
   } state_t;

   // Advances an MSB-first, non-reflected CRC16 by one whole byte.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic [7:0]  data,
                                              input logic [15:0] poly);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ poly) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational one-byte CRC16 update: crc_out = CRC of crc_in extended by data.
module crc16_byte_step
   import crc16_pkg::*;
#(
   parameter logic [15:0] POLY = CRC16_POLY
) (
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   assign crc_out = crc16_step(crc_in, data, POLY);

endmodule

// File: rtl/crc16_frame_tx.sv
// Transmit framer: forwards payload bytes through a single output register and
// appends the running CRC16 as two trailer bytes (MSB first) after the last byte.
module crc16_frame_tx
   import crc16_pkg::*;
#(
   parameter logic [15:0] POLY   = CRC16_POLY,
   parameter logic [15:0] INIT   = CRC16_INIT,
   parameter logic [15:0] XOROUT = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_data,
   output logic        m_last,
   output logic [15:0] crc_out,
   output logic        frame_done
);

   state_t      state;
   state_t      state_next;
   logic [15:0] crc_reg;
   logic [15:0] crc_next;
   logic [15:0] fcs;
   logic        free;
   logic        accept;

   crc16_byte_step #(.POLY(POLY)) u_step (
      .crc_in  (crc_reg),
      .data    (s_data),
      .crc_out (crc_next)
   );

   // The output register can take a new byte when empty or draining this cycle.
   assign free    = !m_valid || m_ready;
   assign s_ready = (state == DATA) && free;
   assign accept  = s_valid && s_ready;
   assign fcs     = crc_reg ^ XOROUT;

   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         DATA:    if (accept && s_last) state_next = CRC_HI;
         CRC_HI:  if (free)             state_next = CRC_LO;
         CRC_LO:  if (free)             state_next = DATA;
         default:                       state_next = DATA;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= DATA;
         crc_reg    <= INIT;
         m_valid    <= 1'b0;
         m_data     <= 8'h00;
         m_last     <= 1'b0;
         crc_out    <= 16'h0000;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         frame_done <= m_valid && m_ready && m_last;
         if (accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc_reg <= crc_next;
         end else if (state == CRC_HI && free) begin
            m_data  <= fcs[15:8];
            m_valid <= 1'b1;
            m_last  <= 1'b0;
         end else if (state == CRC_LO && free) begin
            m_data  <= fcs[7:0];
            m_valid <= 1'b1;
            m_last  <= 1'b1;
            crc_out <= fcs;
            crc_reg <= INIT;
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Randomised self-checking bench for crc16_frame_tx against a bit-serial CRC model.
module tb_crc16_frame_tx;

   typedef logic [7:0] bytes_t[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_ready, s_last;
   logic [7:0]  s_data;
   logic        m_valid, m_ready, m_last;
   logic [7:0]  m_data;
   logic [15:0] crc_out;
   logic        frame_done;

   crc16_frame_tx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .crc_out    (crc_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Source and expectation queues.
   logic [7:0]  src_data[$];
   logic        src_last[$];
   logic [7:0]  exp_bytes[$];
   logic        exp_last[$];
   logic [15:0] exp_crc[$];

   int   valid_pct = 100;
   int   ready_pct = 100;
   int   accepted  = 0;
   int   bubbles   = 0;
   logic seen_out  = 1'b0;
   logic done_pending = 1'b0;
   logic prev_hold = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;
   logic in_xfer, out_xfer;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference CRC: polynomial division one message bit at a time.
   function automatic logic [15:0] model_crc(input bytes_t msg);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      foreach (msg[i]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ msg[i][b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c ^ 16'h0000;
   endfunction

   task automatic add_frame(input bytes_t msg);
      logic [15:0] crc;
      crc = model_crc(msg);
      foreach (msg[i]) begin
         src_data.push_back(msg[i]);
         src_last.push_back(i == msg.size() - 1);
         exp_bytes.push_back(msg[i]);
         exp_last.push_back(1'b0);
      end
      exp_bytes.push_back(crc[15:8]); exp_last.push_back(1'b0);
      exp_bytes.push_back(crc[7:0]);  exp_last.push_back(1'b1);
      exp_crc.push_back(crc);
   endtask

   task automatic drive();
      if (src_data.size() > 0 && $urandom_range(99) < valid_pct) begin
         s_valid = 1'b1;
         s_data  = src_data[0];
         s_last  = src_last[0];
      end else begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
         s_last  = 1'($urandom);
      end
      m_ready = ($urandom_range(99) < ready_pct);
   endtask

   // Observe on the falling edge, then advance and re-drive after the rising edge.
   task automatic step_cycle();
      logic el;
      @(negedge clk);
      in_xfer  = s_valid && s_ready;
      out_xfer = m_valid && m_ready;
      if (prev_hold) begin
         check("hold_valid", m_valid, 1'b1);
         check("hold_data", m_data, prev_data);
         check("hold_last", m_last, prev_last);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      check("frame_done", frame_done, done_pending);
      if (frame_done) begin
         if (exp_crc.size() == 0) check("extra_frame_done", 1, 0);
         else check("crc_out", crc_out, exp_crc.pop_front());
      end
      done_pending = 1'b0;
      if (out_xfer) begin
         seen_out = 1'b1;
         if (exp_bytes.size() == 0) begin
            check("extra_byte", {24'h0, m_data}, 32'h1ff);
         end else begin
            el = exp_last.pop_front();
            check("m_data", m_data, exp_bytes.pop_front());
            check("m_last", m_last, el);
            done_pending = el;
         end
      end else if (seen_out && exp_bytes.size() > 0) begin
         bubbles++;
      end
      @(posedge clk);
      #1;
      if (in_xfer) begin
         void'(src_data.pop_front());
         void'(src_last.pop_front());
         accepted++;
      end
      drive();
   endtask

   task automatic run_drain(input int budget);
      int n = 0;
      while ((src_data.size() > 0 || exp_bytes.size() > 0 || done_pending) && n < budget) begin
         step_cycle();
         n++;
      end
      if (n >= budget) check("drain_timeout", 1, 0);
      for (int i = 0; i < 3; i++) step_cycle();
   endtask

   task automatic check_reset_outputs();
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, 8'h00);
      check("rst_m_last", m_last, 1'b0);
      check("rst_crc_out", crc_out, 16'h0000);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_s_ready", s_ready, 1'b1);
   endtask

   initial begin
      bytes_t msg;
      bytes_t chk;

      for (int i = 0; i < 9; i++) chk.push_back(8'(8'h31 + i));

      rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;

      // Single byte 01 -> 01, 10, 21.
      valid_pct = 100; ready_pct = 100;
      msg = {}; msg.push_back(8'h01);
      add_frame(msg);
      run_drain(200);
      check("crc_01", crc_out, 16'h1021);

      // "123456789" -> trailer 31 C3.
      add_frame(chk);
      run_drain(200);
      check("crc_check", crc_out, 16'h31C3);

      // Back-to-back single-byte frames with no idle cycle.
      msg = {}; msg.push_back(8'hFF); add_frame(msg);
      msg = {}; msg.push_back(8'h00); add_frame(msg);
      bubbles = 0; seen_out = 1'b0;
      run_drain(200);
      check("b2b_bubbles", bubbles, 0);
      check("crc_00", crc_out, 16'h0000);

      // "123456789" with input gaps and 50% backpressure.
      valid_pct = 60; ready_pct = 50;
      add_frame(chk);
      run_drain(2000);
      check("crc_check_stall", crc_out, 16'h31C3);

      // Random frames under random stalls.
      valid_pct = 70; ready_pct = 60;
      for (int f = 0; f < 20; f++) begin
         msg = {};
         for (int i = 0; i < int'($urandom_range(12, 1)); i++) msg.push_back(8'($urandom));
         add_frame(msg);
      end
      run_drain(5000);

      // Abort after 4 accepted bytes, then resend with s_valid high at release.
      valid_pct = 100; ready_pct = 100;
      add_frame(chk);
      accepted = 0;
      for (int n = 0; n < 50 && accepted < 4; n++) step_cycle();
      check("abort_accepted", accepted, 4);
      rst_n = 1'b0;
      src_data.delete(); src_last.delete();
      exp_bytes.delete(); exp_last.delete(); exp_crc.delete();
      done_pending = 1'b0; prev_hold = 1'b0;
      add_frame(chk);
      s_valid = 1'b1; s_data = src_data[0]; s_last = src_last[0]; m_ready = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_m_valid", m_valid, 1'b1);
      check("first_m_data", m_data, 8'h31);
      void'(src_data.pop_front());
      void'(src_last.pop_front());
      drive();
      run_drain(200);
      check("crc_after_abort", crc_out, 16'h31C3);
      check("no_stale_crc", exp_crc.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/crc16_frame_tx.md
Name: crc16_frame_tx

Overview:
- Transmit-side framing stage placed directly downstream of the byte-wise CRC16 generator domain (polynomial X^16+X^12+X^5+1).
- Accepts a byte stream framed by a last flag and accumulates a running CRC16 over every byte of the frame.
- Re-emits the payload on an output byte stream, then appends the 16-bit CRC as two trailer bytes, MSB first.
- Sits between the byte source (packetiser) and the serialiser/line interface.

Parameters:
- POLY, 16'h1021, generator polynomial (X^16+X^12+X^5+1); MSB-first, non-reflected.
- INIT, 16'h0000, CRC register value at the start of every frame.
- XOROUT, 16'h0000, value XORed onto the final CRC before it is emitted.

Ports:
- clk  in  1  single clock; all flops on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  block accepts the input byte this cycle.
- s_data  in  8  input payload byte.
- s_last  in  1  marks the final payload byte of the frame.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts the output byte.
- m_data  out  8  output byte (payload or CRC trailer).
- m_last  out  1  high only on the CRC LSB trailer byte.
- crc_out  out  16  final CRC of the last completed frame (after XOROUT).
- frame_done  out  1  one-cycle pulse when the CRC LSB byte is accepted downstream.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to DATA.
  - crc_reg=INIT; m_valid=0; m_data=0; m_last=0; crc_out=0; frame_done=0.
  - s_ready is combinational and reads 1 in reset: state is DATA and the output register is empty.
- Handshakes:
  - Input transfer when s_valid & s_ready.
  - Output transfer when m_valid & m_ready.
  - m_valid, once high, holds m_data and m_last stable until transferred.
- Output register: single stage; the "free" condition is (!m_valid | m_ready).
- s_ready = (state==DATA) & free.
- CRC update per accepted byte d:
  - c = crc_reg ^ {d,8'h00}.
  - Repeat 8 times: c = c[15] ? ((c<<1) ^ POLY) : (c<<1), truncated to 16 bits.
  - crc_reg <= c.
- State DATA:
  - Each accepted byte is loaded into m_data, m_valid=1, m_last=0, and crc_reg is updated.
  - Latency: accept at cycle t gives m_valid with that byte at t+1.
  - If s_last is high on the accepted byte, go to CRC_HI.
- State CRC_HI:
  - When free: m_data=fcs[15:8], m_valid=1, m_last=0, then go to CRC_LO.
  - fcs = crc_reg ^ XOROUT, computed from crc_reg, which already includes the last byte.
- State CRC_LO:
  - When free: m_data=fcs[7:0], m_last=1, crc_out<=fcs, crc_reg<=INIT, then go to DATA.
- frame_done pulses for one cycle in the cycle after the m_last byte transfers.
- Back-to-back frames: in the cycle where state returns to DATA with the output register holding the LSB, s_ready = m_ready.
  - Inter-frame gap is therefore zero bubbles when m_ready is held at 1.
- Zero-length frames are not possible. A frame with only one byte (s_last on its first byte) is legal and produces 3 output bytes.
- s_valid=0 mid-frame: no state change, CRC held; m_valid drops after its byte drains.
- m_ready=0 (backpressure): everything holds; no byte is lost or duplicated.
- Async reset mid-frame: the partial frame is discarded and no trailer is emitted. The next accepted byte starts a new frame with crc_reg=INIT.
- s_data and s_last are ignored when no transfer occurs.

Decomposition:
- Package crc16_pkg holds:
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'h0000.
  - State enum {DATA, CRC_HI, CRC_LO} as a 2-bit typedef.
  - A byte-step function prototype description.
- One sub-module, crc16_byte_step: purely combinational, (crc_in[15:0], data[7:0]) -> crc_out[15:0] with POLY as a parameter.
- The top holds the FSM, output register, crc_reg, crc_out and frame_done.

Test Plan:
- Single byte 8'h01 with s_last, m_ready=1 -> outputs 01, 10, 21; m_last on 21; crc_out=16'h1021; frame_done one pulse.
- Frame ASCII "123456789" (31..39), last on 39 -> 9 payload bytes, then C3 on m_last after 31; crc_out=16'h31C3.
- Single byte 8'hFF, then immediately single byte 8'h00 back-to-back -> FF,1E,F0 then 00,00,00; no idle cycle between frames; crc_out 16'h1EF0 then 16'h0000.
- "123456789" with random s_valid gaps and m_ready low 50% of cycles -> byte stream and crc_out are identical to the no-stall case; m_data stable while m_valid & !m_ready.
- rst_n pulsed low after 4 bytes of "123456789", then "123456789" resent -> output registers 0 during reset; no trailer for the aborted frame; new frame trailer 31,C3.
- Reset release with s_valid=1 on the first edge -> first byte accepted that cycle; m_valid=1 exactly one cycle later.
